// File: rtl/eth_phy_10g_link_pkg.sv
// Shared encodings and constants for the eth_phy_10g link bring-up sequencer.
package eth_phy_10g_link_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RESET     = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_PRBS      = 3'd3,
    ST_LINK_UP   = 3'd4,
    ST_FAULT     = 3'd5
  } link_state_e;

  localparam int unsigned RETRY_W       = 4;
  localparam int unsigned SETTLE_CYCLES = 2;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/eth_link_timer.sv
// Loadable down-counter with a terminal-count flag; reloaded on each timed state entry.
module eth_link_timer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  logic [WIDTH-1:0] count_q, count_d;

  // NOTE: assign a default first in always_comb so no path leaves count_d unassigned (no latch).
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign tc    = (count_q == '0);

endmodule

// File: rtl/eth_phy_10g_link_ctrl.sv
// Link bring-up / PRBS31 self-test sequencer for eth_phy_10g (rx_clk domain).
// Define ETH_PHY_LINK_CTRL_STATS_EN to add link_drop_count and link_uptime outputs.
module eth_phy_10g_link_ctrl
  import eth_phy_10g_link_pkg::*;
#(
  parameter int unsigned RESET_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT    = 20000,
  parameter int unsigned PRBS_CYCLES     = 4096,
  parameter int unsigned ERR_THRESHOLD   = 0,
  parameter int unsigned MAX_RETRIES     = 3,
  parameter int unsigned ERR_TOTAL_WIDTH = 32
) (
  input  logic                       rx_clk,
  input  logic                       rx_rst,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       prbs_test_en,
  input  logic                       rx_block_lock,
  input  logic                       rx_status,
  input  logic                       rx_high_ber,
  input  logic [6:0]                 rx_error_count,
  output logic                       phy_reset_req,
  output logic                       cfg_tx_prbs31_enable,
  output logic                       cfg_rx_prbs31_enable,
  output logic                       link_up,
  output logic                       prbs_done,
  output logic                       prbs_pass,
  output logic [ERR_TOTAL_WIDTH-1:0] prbs_err_total,
  output logic [3:0]                 retry_count,
  output logic                       fault,
  output logic [2:0]                 state
`ifdef ETH_PHY_LINK_CTRL_STATS_EN
  ,
  output logic [15:0]                link_drop_count,
  output logic [31:0]                link_uptime
`endif
);

  localparam int unsigned EW      = ERR_TOTAL_WIDTH;
  localparam int unsigned TIMER_W =
    $clog2(max3(RESET_CYCLES, LOCK_TIMEOUT, PRBS_CYCLES + SETTLE_CYCLES) + 1);

  link_state_e        state_q, state_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [EW-1:0]      total_q, total_d, total_acc;
  logic [EW:0]        err_sum;
  logic               test_en_q, test_en_d, pass_q, pass_d, done_q, done_d;
  logic               req_q, req_d, link_up_q, link_up_d, fault_q, fault_d, prbs_en_q, prbs_en_d;
  logic               fail, lock_ok;
  logic               tmr_load, tmr_tc;
  logic [TIMER_W-1:0] tmr_load_val, tmr_count;

  eth_link_timer #(.WIDTH(TIMER_W)) u_timer (
    .clk      (rx_clk),
    .rst      (rx_rst),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .count    (tmr_count),
    .tc       (tmr_tc)
  );

  assign lock_ok   = rx_block_lock && rx_status && !rx_high_ber;
  assign err_sum   = {1'b0, total_q} + (EW + 1)'(rx_error_count);
  assign total_acc = err_sum[EW] ? '1 : err_sum[EW-1:0];

  always_comb begin
    state_d   = state_q;
    retry_d   = retry_q;
    test_en_d = test_en_q;
    total_d   = total_q;
    pass_d    = pass_q;
    done_d    = 1'b0;
    fail      = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_FAULT: begin
        if (start) begin
          state_d   = ST_RESET;
          retry_d   = '0;
          test_en_d = prbs_test_en;
        end
      end
      ST_RESET: if (tmr_tc) state_d = ST_WAIT_LOCK;
      ST_WAIT_LOCK: begin
        if (lock_ok)     state_d = test_en_q ? ST_PRBS : ST_LINK_UP;
        else if (tmr_tc) fail    = 1'b1;
      end
      ST_PRBS: begin
        if (!rx_block_lock) begin
          fail = 1'b1;
        end else begin
          // The two highest counts are the settle cycles; the window follows.
          if (tmr_count < TIMER_W'(PRBS_CYCLES)) total_d = total_acc;
          if (tmr_tc) begin
            done_d = 1'b1;
            pass_d = (total_acc <= EW'(ERR_THRESHOLD));
            if (pass_d) state_d = ST_LINK_UP;
            else        fail    = 1'b1;
          end
        end
      end
      ST_LINK_UP: begin
        if (!rx_block_lock || rx_high_ber) begin
          state_d = ST_RESET;
          retry_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (fail) begin
      if (retry_q == RETRY_W'(MAX_RETRIES)) begin
        state_d = ST_FAULT;
      end else begin
        state_d = ST_RESET;
        retry_d = (retry_q == '1) ? retry_q : retry_q + 1'b1;
      end
    end

    if (state_d == ST_PRBS && state_q != ST_PRBS) total_d = '0;

    if (abort) begin
      state_d   = ST_IDLE;
      retry_d   = retry_q;
      test_en_d = test_en_q;
      total_d   = total_q;
      pass_d    = pass_q;
      done_d    = 1'b0;
    end

    req_d     = (state_d == ST_RESET);
    link_up_d = (state_d == ST_LINK_UP);
    fault_d   = (state_d == ST_FAULT);
    prbs_en_d = (state_d == ST_PRBS);

    tmr_load = (state_d != state_q);
    unique case (state_d)
      ST_RESET:     tmr_load_val = TIMER_W'(RESET_CYCLES - 1);
      ST_WAIT_LOCK: tmr_load_val = TIMER_W'(LOCK_TIMEOUT - 1);
      ST_PRBS:      tmr_load_val = TIMER_W'(PRBS_CYCLES + SETTLE_CYCLES - 1);
      default:      tmr_load_val = '0;
    endcase
  end

  always_ff @(posedge rx_clk) begin
    if (rx_rst) begin
      state_q   <= ST_IDLE;
      retry_q   <= '0;
      test_en_q <= 1'b0;
      total_q   <= '0;
      pass_q    <= 1'b0;
      done_q    <= 1'b0;
      req_q     <= 1'b0;
      link_up_q <= 1'b0;
      fault_q   <= 1'b0;
      prbs_en_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      retry_q   <= retry_d;
      test_en_q <= test_en_d;
      total_q   <= total_d;
      pass_q    <= pass_d;
      done_q    <= done_d;
      req_q     <= req_d;
      link_up_q <= link_up_d;
      fault_q   <= fault_d;
      prbs_en_q <= prbs_en_d;
    end
  end

  assign phy_reset_req        = req_q;
  assign cfg_tx_prbs31_enable = prbs_en_q;
  assign cfg_rx_prbs31_enable = prbs_en_q;
  assign link_up              = link_up_q;
  assign prbs_done            = done_q;
  assign prbs_pass            = pass_q;
  assign prbs_err_total       = total_q;
  assign retry_count          = retry_q;
  assign fault                = fault_q;
  assign state                = state_q;

`ifdef ETH_PHY_LINK_CTRL_STATS_EN
  logic [15:0] drop_q, drop_d;
  logic [31:0] uptime_q, uptime_d;

  always_comb begin
    drop_d   = drop_q;
    uptime_d = uptime_q;
    if (state_q == ST_LINK_UP && state_d == ST_RESET && drop_q != '1) drop_d = drop_q + 1'b1;
    if (state_d == ST_LINK_UP && state_q != ST_LINK_UP) begin
      uptime_d = '0;
    end else if (state_q == ST_LINK_UP && uptime_q != '1) begin
      uptime_d = uptime_q + 1'b1;
    end
  end

  always_ff @(posedge rx_clk) begin
    if (rx_rst) begin
      drop_q   <= '0;
      uptime_q <= '0;
    end else begin
      drop_q   <= drop_d;
      uptime_q <= uptime_d;
    end
  end

  assign link_drop_count = drop_q;
  assign link_uptime     = uptime_q;
`endif

endmodule

// File: tb/tb_eth_phy_10g_link_ctrl.sv
// Directed + randomized bench for eth_phy_10g_link_ctrl with a timing/arithmetic reference model.
module tb_eth_phy_10g_link_ctrl;

  localparam int RC = 4, LT = 50, PC = 100, THR = 0, MR = 2, EW = 8, SETTLE = 2;
  localparam int WIN = PC + SETTLE;

  logic          rx_clk = 1'b0;
  logic          rx_rst, start, abort, prbs_test_en;
  logic          rx_block_lock, rx_status, rx_high_ber;
  logic [6:0]    rx_error_count;
  logic          phy_reset_req, cfg_tx_prbs31_enable, cfg_rx_prbs31_enable;
  logic          link_up, prbs_done, prbs_pass, fault;
  logic [EW-1:0] prbs_err_total;
  logic [3:0]    retry_count;
  logic [2:0]    state;
`ifdef ETH_PHY_LINK_CTRL_STATS_EN
  logic [15:0]   link_drop_count;
  logic [31:0]   link_uptime;
`endif

  int checks = 0;
  int errors = 0;
  int win_err [WIN];

  always #5 rx_clk = ~rx_clk;

  eth_phy_10g_link_ctrl #(
    .RESET_CYCLES(RC), .LOCK_TIMEOUT(LT), .PRBS_CYCLES(PC),
    .ERR_THRESHOLD(THR), .MAX_RETRIES(MR), .ERR_TOTAL_WIDTH(EW)
  ) dut (
    .rx_clk(rx_clk), .rx_rst(rx_rst), .start(start), .abort(abort),
    .prbs_test_en(prbs_test_en), .rx_block_lock(rx_block_lock), .rx_status(rx_status),
    .rx_high_ber(rx_high_ber), .rx_error_count(rx_error_count),
    .phy_reset_req(phy_reset_req), .cfg_tx_prbs31_enable(cfg_tx_prbs31_enable),
    .cfg_rx_prbs31_enable(cfg_rx_prbs31_enable), .link_up(link_up), .prbs_done(prbs_done),
    .prbs_pass(prbs_pass), .prbs_err_total(prbs_err_total), .retry_count(retry_count),
    .fault(fault), .state(state)
`ifdef ETH_PHY_LINK_CTRL_STATS_EN
    , .link_drop_count(link_drop_count), .link_uptime(link_uptime)
`endif
  );

  task automatic tick();
    @(posedge rx_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: window total is the saturated sum of errors after the settle cycles.
  function automatic int model_total(input int upto);
    longint s = 0;
    for (int i = SETTLE; i < upto; i++) s += win_err[i];
    return (s > longint'((1 << EW) - 1)) ? ((1 << EW) - 1) : int'(s);
  endfunction

  task automatic wait_cfg(input string tag, output int n);
    n = 0;
    while (!cfg_tx_prbs31_enable && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_prbs_entry_cycles"}, n, RC + 1);
  endtask

  task automatic drive_window(input int upto, output int done_cnt, output int cfg_cnt,
                              output int done_at);
    done_cnt = 0; cfg_cnt = 0; done_at = -1;
    for (int i = 0; i < upto; i++) begin
      rx_error_count = 7'(win_err[i]);
      tick();
      if (prbs_done) begin done_cnt++; done_at = i + 1; end
      if (cfg_tx_prbs31_enable && cfg_rx_prbs31_enable) cfg_cnt++;
    end
    rx_error_count = '0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, d, k, dc, cc, da, rises, cfg_seen, early, prev_req;
    rx_rst = 1'b1; start = 1'b0; abort = 1'b0; prbs_test_en = 1'b0;
    rx_block_lock = 1'b0; rx_status = 1'b0; rx_high_ber = 1'b0; rx_error_count = '0;
    repeat (3) tick();
    check("rst_state", state, 0);
    check("rst_req", phy_reset_req, 0);
    check("rst_link_up", link_up, 0);
    check("rst_fault", fault, 0);
    check("rst_cfg_tx", cfg_tx_prbs31_enable, 0);
    check("rst_cfg_rx", cfg_rx_prbs31_enable, 0);
    check("rst_done", prbs_done, 0);
    check("rst_pass", prbs_pass, 0);
    check("rst_total", prbs_err_total, 0);
    check("rst_retry", retry_count, 0);
    rx_rst = 1'b0;
    tick();

    // Plain bring-up without PRBS, lock arriving after a random delay.
    prbs_test_en = 1'b0; start = 1'b1; tick(); start = 1'b0;
    n = 0; cfg_seen = 0;
    while (phy_reset_req && n < 20) begin n++; tick(); end
    check("t1_req_cycles", n, RC);
    check("t1_state_wait", state, 2);
    d = $urandom_range(0, 40); early = 0;
    repeat (d) begin
      tick();
      if (link_up) early = 1;
      if (cfg_tx_prbs31_enable || cfg_rx_prbs31_enable) cfg_seen = 1;
    end
    check("t1_no_early_link", early, 0);
    rx_block_lock = 1'b1; rx_status = 1'b1; tick();
    check("t1_link_up", link_up, 1);
    check("t1_state_up", state, 4);
    check("t1_cfg_quiet", cfg_seen | cfg_tx_prbs31_enable, 0);

    // High BER in LINK_UP restarts bring-up without counting a failure.
    rx_high_ber = 1'b1; tick(); rx_high_ber = 1'b0;
    check("t2_link_drop", link_up, 0);
    check("t2_state_reset", state, 1);
    check("t2_retry", retry_count, 0);
    check("t2_req", phy_reset_req, 1);
`ifdef ETH_PHY_LINK_CTRL_STATS_EN
    check("t2_drop_count", link_drop_count, 1);
`endif
    n = 0;
    while (!link_up && n < 20) begin tick(); n++; end
    check("t2_relink_cycles", n, RC + 1);
    do_abort();
    check("abort_state", state, 0);
    check("abort_link_up", link_up, 0);

    // PRBS pass: settle cycles carry random errors that must be ignored.
    foreach (win_err[i]) win_err[i] = (i < SETTLE) ? int'($urandom_range(1, 127)) : 0;
    prbs_test_en = 1'b1; start = 1'b1; tick(); start = 1'b0; prbs_test_en = 1'b0;
    wait_cfg("t3", n);
    drive_window(WIN, dc, cc, da);
    check("t3_prbs_cycles", cc + 1, WIN);
    check("t3_done_count", dc, 1);
    check("t3_done_at", da, WIN);
    check("t3_total", prbs_err_total, model_total(WIN));
    check("t3_pass", prbs_pass, (model_total(WIN) <= THR) ? 1 : 0);
    check("t3_state_up", state, 4);
    check("t3_cfg_off", cfg_tx_prbs31_enable | cfg_rx_prbs31_enable, 0);
    do_abort();

    // Lock loss inside PRBS: failed attempt, no done pulse, pass held.
    foreach (win_err[i]) win_err[i] = 0;
    prbs_test_en = 1'b1; start = 1'b1; tick(); start = 1'b0;
    wait_cfg("t3b", n);
    k = $urandom_range(0, WIN - 1);
    drive_window(k, dc, cc, da);
    rx_block_lock = 1'b0; tick(); rx_block_lock = 1'b1;
    check("t3b_done_none", dc + prbs_done, 0);
    check("t3b_state_reset", state, 1);
    check("t3b_retry", retry_count, 1);
    check("t3b_pass_held", prbs_pass, 1);
    do_abort();

    // PRBS fail: a single error of 3 somewhere in the window.
    foreach (win_err[i]) win_err[i] = (i < SETTLE) ? int'($urandom_range(0, 127)) : 0;
    win_err[$urandom_range(SETTLE, WIN - 1)] = 3;
    prbs_test_en = 1'b1; start = 1'b1; tick(); start = 1'b0;
    wait_cfg("t4", n);
    drive_window(WIN, dc, cc, da);
    check("t4_done_count", dc, 1);
    check("t4_total", prbs_err_total, model_total(WIN));
    check("t4_pass", prbs_pass, (model_total(WIN) <= THR) ? 1 : 0);
    check("t4_retry", retry_count, 1);
    check("t4_state_reset", state, 1);
    do_abort();

    // Saturation with 127 per cycle, then abort mid-window.
    foreach (win_err[i]) win_err[i] = 127;
    for (int r = 0; r < 2; r++) begin
      k = (r == 0) ? int'($urandom_range(3, 4)) : int'($urandom_range(5, WIN - 2));
      prbs_test_en = 1'b1; start = 1'b1; tick(); start = 1'b0;
      wait_cfg("t5", n);
      drive_window(k, dc, cc, da);
      check("t5_total", prbs_err_total, model_total(k));
      check("t5_no_done", dc, 0);
      do_abort();
      check("t5_abort_state", state, 0);
      check("t5_abort_cfg", cfg_tx_prbs31_enable | cfg_rx_prbs31_enable, 0);
    end

    // Lock never arrives: MR+1 timeouts then FAULT.
    rx_block_lock = 1'b0; rx_status = 1'b0;
    prbs_test_en = 1'($urandom_range(0, 1)); start = 1'b1; tick(); start = 1'b0;
    n = 0; rises = 1; prev_req = phy_reset_req;
    while (!fault && n < 400) begin
      tick(); n++;
      if (phy_reset_req && !prev_req) rises++;
      prev_req = phy_reset_req;
    end
    check("t6_fault_cycles", n, (MR + 1) * (RC + LT));
    check("t6_attempts", rises, MR + 1);
    check("t6_retry", retry_count, MR);
    check("t6_state_fault", state, 5);
    check("t6_fault", fault, 1);
    check("t6_req_low", phy_reset_req, 0);

    // Restart from FAULT.
    rx_block_lock = 1'b1; rx_status = 1'b1;
    prbs_test_en = 1'b0; start = 1'b1; tick(); start = 1'b0;
    check("t7_fault_clear", fault, 0);
    check("t7_state_reset", state, 1);
    check("t7_retry", retry_count, 0);
    n = 0;
    while (!link_up && n < 20) begin tick(); n++; end
    check("t7_link_cycles", n, RC + 1);

    // abort beats start, in LINK_UP and in IDLE.
    abort = 1'b1; start = 1'b1; tick();
    check("t8_abort_from_up", state, 0);
    tick(); start = 1'b0; abort = 1'b0;
    check("t8_idle_start_abort", state, 0);
    check("t8_req", phy_reset_req, 0);
    tick();
    check("t8_still_idle", state, 0);

    // Synchronous reset mid-operation.
    start = 1'b1; tick(); start = 1'b0; tick();
    check("t9_in_reset", state, 1);
    rx_rst = 1'b1; tick();
    check("t9_rst_state", state, 0);
    check("t9_rst_req", phy_reset_req, 0);
    check("t9_rst_total", prbs_err_total, 0);
    rx_rst = 1'b0; tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
